// File: rtl/dft_pkg.sv
// Shared types and widths for the processor-to-uart_tx byte path.
package dft_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is deliberately left out of reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Decouples processor byte bursts from uart_tx line rate through a FIFO; flags drops and a stalled transmitter.
//
// state     | meaning
// IDLE      | wait for a queued byte and an idle uart_tx, then pop it
// SEND      | one-cycle start strobe to uart_tx
// WAIT_DONE | wait for end-of-frame pulse, bounded by DONE_TIMEOUT
// GAP       | one cycle to let uart_tx finish its cleanup state
module uart_tx_feeder
  import dft_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int          ADDR_W       = $clog2(DEPTH),
  parameter int unsigned DONE_TIMEOUT = 2048
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Byte_DV,
  input  logic [BYTE_W-1:0] i_Byte,
  output logic              o_Ready,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Tx_DV,
  output logic [BYTE_W-1:0] o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Overflow,
  output logic              o_Timeout
);

  localparam int TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

  tx_feed_state_t    state;
  logic [TO_W-1:0]   timer;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign pop     = (state == IDLE) && !fifo_empty && !i_Tx_Active;
  assign o_Ready = !fifo_full;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk_sys (i_Clock),
    .rst_b   (i_Rst_n),
    .push    (i_Byte_DV),
    .pop     (pop),
    .din     (i_Byte),
    .dout    (fifo_dout),
    .count   (o_Count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The timer is zero during SEND and counts that cycle, so o_Timeout rises DONE_TIMEOUT clocks after SEND.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Overflow <= 1'b0;
      o_Timeout  <= 1'b0;
    end else begin
      o_Tx_DV <= 1'b0;
      if (i_Byte_DV && fifo_full) o_Overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            o_Tx_Byte <= fifo_dout;
            o_Tx_DV   <= 1'b1;
            timer     <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          timer <= timer + 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_Tx_Done) begin
            state <= GAP;
          end else if ((DONE_TIMEOUT != 0) && (timer >= TO_LAST)) begin
            o_Timeout <= 1'b1;
            state     <= GAP;
          end else if (DONE_TIMEOUT != 0) begin
            timer <= timer + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
